encrypt_stream: RTL and testbench



---
 rtl/encrypt_stream.sv | 168 ++++++++++++++++
 tb/tb_encrypt_stream.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_stream.sv
// -----------------------------------------------------------------------------
// encrypt_stream
//
// Sequential byte-stream encryptor, the transmit-side counterpart of decrypt.
// A start strobe latches a multi-character secret. Plaintext bytes then arrive
// over a valid/ready handshake. Each byte is added (mod 256) to the next secret
// character, cycling through the key. The result leaves through a one-deep
// registered output stage with valid/ready, a last marker and a done pulse.
//
// Parameters
//   p_secret_length : number of 8-bit characters in the secret (>= 1)
//   p_index_width   : key index width, 2**p_index_width >= p_secret_length
//
// Ports
//   i_w_clk          : clock, rising edge
//   i_w_rst          : synchronous active-high reset
//   i_w_start        : one-cycle strobe, latches secret and begins a message
//   i_w_secret       : secret, most significant byte is character 0
//   i_w_text         : plaintext byte
//   i_w_text_valid   : plaintext byte present
//   i_w_text_last    : plaintext byte is the final byte of the message
//   o_r_text_ready   : block accepts plaintext this cycle
//   o_r_cipher       : cipher byte
//   o_r_cipher_valid : cipher byte present
//   o_r_cipher_last  : cipher byte is the final byte of the message
//   i_w_cipher_ready : downstream accepts the cipher byte
//   o_r_busy         : message in progress
//   o_r_done         : one-cycle pulse after the last cipher byte handshakes
//
// Optional feature macro: ENCRYPT_ALPHA_ONLY_EN
//   When defined, bytes outside 'A'..'Z' and 'a'..'z' pass through unchanged
//   and do not advance the key index.
// -----------------------------------------------------------------------------
module encrypt_stream #(
  parameter int p_secret_length = 6,
  parameter int p_index_width   = 3
) (
  input  logic                         i_w_clk,
  input  logic                         i_w_rst,
  input  logic                         i_w_start,
  input  logic [p_secret_length*8-1:0] i_w_secret,
  input  logic [7:0]                   i_w_text,
  input  logic                         i_w_text_valid,
  input  logic                         i_w_text_last,
  output logic                         o_r_text_ready,
  output logic [7:0]                   o_r_cipher,
  output logic                         o_r_cipher_valid,
  output logic                         o_r_cipher_last,
  input  logic                         i_w_cipher_ready,
  output logic                         o_r_busy,
  output logic                         o_r_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [p_secret_length*8-1:0] r_key;
  logic [p_index_width-1:0]     r_idx;
  logic [p_index_width-1:0]     w_idx_nxt;
  logic [7:0]                   w_key_chr;
  logic [7:0]                   w_cipher_nxt;
  logic                         w_advance;
  logic                         w_accept;
  logic                         w_handshake;
  logic                         w_start_ok;

  // Truncated 8-bit add, carry discarded.
  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

`ifdef ENCRYPT_ALPHA_ONLY_EN
  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction
`endif

  // Handshake qualifiers. Ready is combinational on the downstream ready so a
  // byte can be replaced in the same cycle it drains (no bubble).
  always_comb begin
    o_r_text_ready = (r_state == S_RUN) && (!o_r_cipher_valid || i_w_cipher_ready);
    w_accept       = i_w_text_valid && o_r_text_ready;
    w_handshake    = o_r_cipher_valid && i_w_cipher_ready;
    // A start in the cycle done is pulsing is ignored.
    w_start_ok     = (r_state == S_IDLE) && i_w_start && !o_r_done;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_accept && i_w_text_last) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_handshake && o_r_cipher_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Key character selection: character 0 sits in the most significant byte.
  always_comb begin
    w_key_chr = 8'h00;
    for (int k = 0; k < p_secret_length; k++) begin
      if (r_idx == p_index_width'(k)) w_key_chr = r_key[8*(p_secret_length-1-k) +: 8];
    end
  end

  // Cipher computation and key index advance.
  always_comb begin
`ifdef ENCRYPT_ALPHA_ONLY_EN
    if (is_letter(i_w_text)) begin
      w_cipher_nxt = add_mod256(i_w_text, w_key_chr);
      w_advance    = 1'b1;
    end else begin
      w_cipher_nxt = i_w_text;
      w_advance    = 1'b0;
    end
`else
    w_cipher_nxt = add_mod256(i_w_text, w_key_chr);
    w_advance    = 1'b1;
`endif
    w_idx_nxt = r_idx;
    if (w_start_ok) begin
      w_idx_nxt = '0;
    end else if (w_accept && w_advance) begin
      if (r_idx == p_index_width'(p_secret_length - 1)) w_idx_nxt = '0;
      else w_idx_nxt = r_idx + 1'b1;
    end
  end

  // ---- registered state, key and one-deep output stage ----
  always_ff @(posedge i_w_clk) begin
    if (i_w_rst) begin
      r_state          <= S_IDLE;
      r_key            <= '0;
      r_idx            <= '0;
      o_r_cipher       <= 8'h00;
      o_r_cipher_valid <= 1'b0;
      o_r_cipher_last  <= 1'b0;
      o_r_busy         <= 1'b0;
      o_r_done         <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      o_r_busy <= (w_state_nxt != S_IDLE);
      o_r_done <= (r_state == S_FLUSH) && (w_state_nxt == S_IDLE);
      if (w_start_ok) r_key <= i_w_secret;
      if (w_accept) begin
        o_r_cipher       <= w_cipher_nxt;
        o_r_cipher_valid <= 1'b1;
        o_r_cipher_last  <= i_w_text_last;
      end else if (w_handshake) begin
        o_r_cipher_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encrypt_stream.sv
module tb_encrypt_stream;
  localparam int L = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [8*L-1:0] secret = '0;
  logic [7:0]     text = 8'h00;
  logic           tv = 1'b0;
  logic           tl = 1'b0;
  logic           cready = 1'b1;
  logic           o_text_ready;
  logic [7:0]     o_cipher;
  logic           o_cipher_valid;
  logic           o_cipher_last;
  logic           o_busy;
  logic           o_done;

  encrypt_stream #(.p_secret_length(L), .p_index_width(3)) dut (
    .i_w_clk          (clk),
    .i_w_rst          (rst),
    .i_w_start        (start),
    .i_w_secret       (secret),
    .i_w_text         (text),
    .i_w_text_valid   (tv),
    .i_w_text_last    (tl),
    .o_r_text_ready   (o_text_ready),
    .o_r_cipher       (o_cipher),
    .o_r_cipher_valid (o_cipher_valid),
    .o_r_cipher_last  (o_cipher_last),
    .i_w_cipher_ready (cready),
    .o_r_busy         (o_busy),
    .o_r_done         (o_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_seen = 0;
  bit         m_active = 0;
  bit         m_running = 0;
  bit         m_done = 0;
  logic [7:0] m_key [L];
  int         m_idx = 0;
  logic [8:0] q[$];
  logic [7:0] got_q[$];

  function automatic bit is_letter(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  // Inputs change #1 after posedge, so at negedge they show what the next edge
  // will sample. Compare first, then advance the model across that edge.
  always @(negedge clk) begin : model
    bit         exp_rdy;
    bit         pre_active;
    bit         pre_done;
    bit         adv;
    logic [8:0] e;
    logic [7:0] c;
    exp_rdy = m_running && (q.size() == 0 || cready);
    if (m_seen) begin
      chk("cipher_valid", o_cipher_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("cipher", o_cipher, q[0][7:0]);
        chk("cipher_last", o_cipher_last, q[0][8]);
      end
      chk("text_ready", o_text_ready, exp_rdy);
      chk("busy", o_busy, m_active);
      chk("done", o_done, m_done);
    end
    if (o_cipher_valid && cready) got_q.push_back(o_cipher);
    if (rst) begin
      m_seen = 1; m_active = 0; m_running = 0; m_done = 0; m_idx = 0;
      q.delete();
    end else if (m_seen) begin
      pre_active = m_active;
      pre_done   = m_done;
      m_done     = 0;
      if (q.size() != 0 && cready) begin
        e = q.pop_front();
        if (e[8]) begin m_active = 0; m_done = 1; end
      end
      if (exp_rdy && tv) begin
        adv = 1;
`ifdef ENCRYPT_ALPHA_ONLY_EN
        adv = is_letter(text);
`endif
        if (adv) begin
          c = 8'((int'(text) + int'(m_key[m_idx])) % 256);
          m_idx = (m_idx + 1) % L;
        end else begin
          c = text;
        end
        q.push_back({tl, c});
        if (tl) m_running = 0;
      end
      if (start && !pre_active && !pre_done) begin
        m_active = 1; m_running = 1; m_idx = 0;
        for (int i = 0; i < L; i++) m_key[i] = 8'((secret >> (8*(L-1-i))) & 48'hFF);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_msg(input logic [8*L-1:0] s);
    secret = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l, output int stalls);
    text = b; tl = l; tv = 1'b1; stalls = 0;
    while (1) begin
      @(negedge clk);
      if (o_text_ready) break;
      stalls++;
      if (stalls > 50) begin chk("send_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    tv = 1'b0; tl = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (1) begin
      @(negedge clk);
      if (o_done) break;
      t++;
      if (t > 50) begin chk("done_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] exp8 [8];
  int st;
  int tot;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cipher_valid", o_cipher_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ready", o_text_ready, 0);
    chk("rst_cipher", o_cipher, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte message: 'E' + 'D' = 0x89, done the cycle after handshake.
    got_q.delete();
    start_msg("DANILA");
    send(8'h45, 1'b1, st);
    @(negedge clk);
    chk("t1_cipher", o_cipher, 8'h89);
    chk("t1_last", o_cipher_last, 1);
    chk("t1_valid", o_cipher_valid, 1);
    @(negedge clk);
    chk("t1_done", o_done, 1);
    chk("t1_busy", o_busy, 0);
    @(posedge clk); #1;

    // Eight bytes, key wraps after six, ready held high.
    exp8 = '{8'h89, 8'h86, 8'h93, 8'h8E, 8'h91, 8'h86, 8'h89, 8'h86};
    got_q.delete(); tot = 0;
    start_msg("DANILA");
    for (int i = 0; i < 8; i++) begin
      send(8'h45, i == 7, st);
      tot += st;
    end
    wait_done();
    chk("t2_no_bubble", tot, 0);
    chk("t2_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("t2_cipher", got_q[i], exp8[i]);

    // Carry discarded.
    got_q.delete();
    start_msg("DANILA"); send(8'hFF, 1'b1, st); wait_done();
    start_msg("DANILA"); send(8'hBC, 1'b1, st); wait_done();
    chk("t3_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t3_ff", got_q[0], 8'h43);
      chk("t3_bc", got_q[1], 8'h00);
    end

    // Backpressure: output held, input stalled, order preserved.
    got_q.delete();
    start_msg("DANILA");
    cready = 1'b0;
    send(8'h45, 1'b0, st);
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_ready", o_text_ready, 0);
      chk("t4_stall_cipher", o_cipher, 8'h89);
      chk("t4_stall_valid", o_cipher_valid, 1);
    end
    @(posedge clk); #1;
    cready = 1'b1;
    send(8'h45, 1'b0, st);
    send(8'h45, 1'b1, st);
    wait_done();
    chk("t4_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("t4_c0", got_q[0], 8'h89);
      chk("t4_c1", got_q[1], 8'h86);
      chk("t4_c2", got_q[2], 8'h93);
    end

    // Reset mid-message, then restart with a fresh key.
    start_msg("DANILA");
    send(8'h45, 1'b0, st);
    send(8'h45, 1'b0, st);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_valid", o_cipher_valid, 0);
    chk("t5_cipher", o_cipher, 0);
    chk("t5_last", o_cipher_last, 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_done", o_done, 0);
    rst = 1'b0;
    got_q.delete();
    start_msg("AAAAAA");
    send(8'h01, 1'b1, st);
    wait_done();
    chk("t5_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("t5_restart", got_q[0], 8'h42);

    // Start held through FLUSH and the done cycle is taken only afterwards.
    got_q.delete();
    start_msg("DANILA");
    send(8'h45, 1'b1, st);
    start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    @(negedge clk);
    chk("t6_busy_again", o_busy, 1);
    @(posedge clk); #1;
    send(8'h45, 1'b1, st);
    wait_done();
    chk("t6_count", got_q.size(), 2);
    if (got_q.size() == 2) chk("t6_second", got_q[1], 8'h89);

`ifdef ENCRYPT_ALPHA_ONLY_EN
    got_q.delete();
    start_msg("DANILA");
    send(8'h45, 1'b0, st);
    send(8'h20, 1'b0, st);
    send(8'h45, 1'b1, st);
    wait_done();
    chk("t7_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("t7_c0", got_q[0], 8'h89);
      chk("t7_c1", got_q[1], 8'h20);
      chk("t7_c2", got_q[2], 8'h86);
    end
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
